// File: rtl/bkg_read_arbiter.sv
// Shares the background RAM read port between display fetch (high priority) and game probe.
// Optional BKG_ARB_FORCE_EN: a starved game request beats a new display request, which is parked for one cycle.
module bkg_read_arbiter #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 160,
    parameter int MAX_WAIT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  scroll,
    input  logic        dsp_req,
    input  logic [7:0]  dsp_row,
    input  logic [7:0]  dsp_col,
    output logic        dsp_valid,
    output logic [23:0] dsp_data,
    input  logic        gm_req,
    input  logic [7:0]  gm_row,
    input  logic [7:0]  gm_col,
    output logic        gm_ack,
    output logic        gm_valid,
    output logic [23:0] gm_data,
    output logic [14:0] ram_read_address,
    input  logic [23:0] ram_data_Out,
    output logic        gm_starved,
    output logic        dsp_drop
);

    function automatic logic [14:0] calc_addr(input logic [7:0] row, input logic [7:0] col,
                                              input logic [7:0] scr);
        logic [8:0]  eff;
        logic [31:0] lin;
        eff = {1'b0, row} + {1'b0, scr};
        if (eff >= 9'(HEIGHT))
            eff = eff - 9'(HEIGHT);
        lin = 32'(eff) * 32'(WIDTH) + 32'(col);
        return lin[14:0];
    endfunction

    logic [14:0] addr_q;
    logic [7:0]  wait_q, wait_d;
    logic        drop_q;
    logic        pend_valid_q, pend_oor_q;
    logic [14:0] pend_addr_q;
    logic        s1_dsp_q, s1_gm_q, s1_oor_q;
    logic        s2_dsp_q, s2_gm_q, s2_oor_q;

    logic [14:0] dsp_addr, gm_addr, iss_addr;
    logic        dsp_oor, gm_oor, iss_oor, iss_any;
    logic        force_gm, grant_dsp, grant_gm;

    assign dsp_addr = calc_addr(dsp_row, dsp_col, scroll);
    assign gm_addr  = calc_addr(gm_row, gm_col, scroll);
    assign dsp_oor  = (32'(dsp_row) >= 32'(HEIGHT)) || (32'(dsp_col) >= 32'(WIDTH));
    assign gm_oor   = (32'(gm_row) >= 32'(HEIGHT)) || (32'(gm_col) >= 32'(WIDTH));

    assign gm_starved = (wait_q >= 8'(MAX_WAIT));

`ifdef BKG_ARB_FORCE_EN
    assign force_gm = !pend_valid_q && dsp_req && gm_req && gm_starved;
`else
    assign force_gm = 1'b0;
`endif

    // A parked display request always wins; a coinciding new dsp_req is lost.
    assign grant_dsp = !pend_valid_q && dsp_req && !force_gm;
    assign grant_gm  = gm_req && !pend_valid_q && (!dsp_req || force_gm);
    assign gm_ack    = grant_gm && !Reset;

    always_comb begin
        iss_any  = 1'b0;
        iss_addr = 15'd0;
        iss_oor  = 1'b0;
        if (pend_valid_q) begin
            iss_any  = 1'b1;
            iss_addr = pend_addr_q;
            iss_oor  = pend_oor_q;
        end else if (grant_dsp) begin
            iss_any  = 1'b1;
            iss_addr = dsp_addr;
            iss_oor  = dsp_oor;
        end else if (grant_gm) begin
            iss_any  = 1'b1;
            iss_addr = gm_addr;
            iss_oor  = gm_oor;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!gm_req || grant_gm)
            wait_d = 8'd0;
        else if (wait_q != 8'hFF)
            wait_d = wait_q + 8'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q       <= 15'd0;
            wait_q       <= 8'd0;
            drop_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_oor_q   <= 1'b0;
            pend_addr_q  <= 15'd0;
            s1_dsp_q     <= 1'b0;
            s1_gm_q      <= 1'b0;
            s1_oor_q     <= 1'b0;
            s2_dsp_q     <= 1'b0;
            s2_gm_q      <= 1'b0;
            s2_oor_q     <= 1'b0;
        end else begin
            // Out-of-range requests leave the RAM address where it was.
            if (iss_any && !iss_oor)
                addr_q <= iss_addr;
            wait_q       <= wait_d;
            if (pend_valid_q && dsp_req)
                drop_q <= 1'b1;
            pend_valid_q <= force_gm;
            if (force_gm) begin
                pend_addr_q <= dsp_addr;
                pend_oor_q  <= dsp_oor;
            end
            s1_dsp_q <= pend_valid_q || grant_dsp;
            s1_gm_q  <= grant_gm;
            s1_oor_q <= iss_oor;
            s2_dsp_q <= s1_dsp_q;
            s2_gm_q  <= s1_gm_q;
            s2_oor_q <= s1_oor_q;
        end
    end

    assign ram_read_address = addr_q;
    assign dsp_drop         = drop_q;
    assign dsp_valid        = s2_dsp_q;
    assign gm_valid         = s2_gm_q;
    assign dsp_data         = (s2_dsp_q && !s2_oor_q) ? ram_data_Out : 24'h000000;
    assign gm_data          = (s2_gm_q && !s2_oor_q) ? ram_data_Out : 24'h000000;

endmodule
